// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, parallel load, logical/arithmetic shifts,
// rotates, and a serial-out sequence that streams a loaded word MSB-first.
module univ_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
  output logic [WIDTH-1:0] dout,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  typedef enum logic [2:0] {
    M_HOLD   = 3'b000,
    M_LOAD   = 3'b001,
    M_SHL    = 3'b010,
    M_SHR    = 3'b011,
    M_ASR    = 3'b100,
    M_ROL    = 3'b101,
    M_ROR    = 3'b110,
    M_SEROUT = 3'b111
  } mode_e;

  localparam int CW = $clog2(WIDTH + 1);
  // Counter value seen on the edge that performs the final shift.
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e          state;
  state_e          state_nxt;
  mode_e           op;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic [WIDTH-1:0] dout_nxt;
  logic            sout_nxt;
  logic            busy_nxt;
  logic            done_nxt;

  assign op = mode_e'(mode);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode: enter SHIFT on SEROUT, leave after the final shift.
  always_comb begin
    state_nxt = state;
    if (en) begin
      case (state)
        IDLE:    if (op == M_SEROUT) state_nxt = SHIFT;
        SHIFT:   if (cnt == LAST)    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output/datapath next values; done defaults low so it can only pulse.
  always_comb begin
    dout_nxt = dout;
    sout_nxt = sout;
    cnt_nxt  = cnt;
    busy_nxt = busy;
    done_nxt = 1'b0;
    if (en) begin
      case (state)
        IDLE: begin
          case (op)
            M_HOLD: ;
            M_LOAD: dout_nxt = din;
            M_SHL: begin
              dout_nxt = {dout[WIDTH-2:0], sin};
              sout_nxt = dout[WIDTH-1];
            end
            M_SHR: begin
              dout_nxt = {sin, dout[WIDTH-1:1]};
              sout_nxt = dout[0];
            end
            M_ASR: begin
              dout_nxt = {dout[WIDTH-1], dout[WIDTH-1:1]};
              sout_nxt = dout[0];
            end
            M_ROL: begin
              dout_nxt = {dout[WIDTH-2:0], dout[WIDTH-1]};
              sout_nxt = dout[WIDTH-1];
            end
            M_ROR: begin
              dout_nxt = {dout[0], dout[WIDTH-1:1]};
              sout_nxt = dout[0];
            end
            M_SEROUT: begin
              dout_nxt = din;
              cnt_nxt  = '0;
              busy_nxt = 1'b1;
            end
            default: ;
          endcase
        end
        SHIFT: begin
          sout_nxt = dout[WIDTH-1];
          dout_nxt = {dout[WIDTH-2:0], sin};
          cnt_nxt  = cnt + CW'(1);
          if (cnt == LAST) begin
            busy_nxt = 1'b0;
            done_nxt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs and shift counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout <= '0;
      sout <= 1'b0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      dout <= dout_nxt;
      sout <= sout_nxt;
      cnt  <= cnt_nxt;
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg at WIDTH=4.
module tb_univ_shift_reg;

  localparam logic [2:0] HOLD   = 3'b000;
  localparam logic [2:0] LOAD   = 3'b001;
  localparam logic [2:0] SHL    = 3'b010;
  localparam logic [2:0] SHR    = 3'b011;
  localparam logic [2:0] ASR    = 3'b100;
  localparam logic [2:0] ROL    = 3'b101;
  localparam logic [2:0] ROR    = 3'b110;
  localparam logic [2:0] SEROUT = 3'b111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [2:0] mode;
  logic [3:0] din;
  logic       sin;
  logic [3:0] dout;
  logic       sout;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  univ_shift_reg #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .mode (mode),
    .din  (din),
    .sin  (sin),
    .dout (dout),
    .sout (sout),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_dout, input logic e_sout,
                         input logic e_busy, input logic e_done);
    chk({tag, ".dout"}, {28'd0, dout}, {28'd0, e_dout});
    chk({tag, ".sout"}, {31'd0, sout}, {31'd0, e_sout});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, e_done});
  endtask

  initial begin
    // Reset overrides an enabled LOAD.
    rst_n = 1'b0; en = 1'b1; mode = LOAD; din = 4'b1010; sin = 1'b0;
    step(); chk_all("reset", 4'b0000, 1'b0, 1'b0, 1'b0);

    // Basic load / shifts / enable gating.
    rst_n = 1'b1;
    step(); chk_all("load1010", 4'b1010, 1'b0, 1'b0, 1'b0);
    mode = SHL; sin = 1'b1;
    step(); chk_all("shl", 4'b0101, 1'b1, 1'b0, 1'b0);
    mode = SHR; sin = 1'b0;
    step(); chk_all("shr", 4'b0010, 1'b1, 1'b0, 1'b0);
    en = 1'b0; mode = SHL;
    step(); chk_all("en0", 4'b0010, 1'b1, 1'b0, 1'b0);
    en = 1'b1; mode = HOLD;
    step(); chk_all("hold", 4'b0010, 1'b1, 1'b0, 1'b0);

    // Arithmetic shift and rotates.
    mode = LOAD; din = 4'b1000;
    step(); chk_all("load1000", 4'b1000, 1'b1, 1'b0, 1'b0);
    mode = ASR;
    step(); chk_all("asr1", 4'b1100, 1'b0, 1'b0, 1'b0);
    step(); chk_all("asr2", 4'b1110, 1'b0, 1'b0, 1'b0);
    sin = 1'b1;
    step(); chk_all("asr3_sin_ignored", 4'b1111, 1'b0, 1'b0, 1'b0);
    sin = 1'b0; mode = LOAD; din = 4'b1001;
    step();
    mode = ROL;
    step(); chk_all("rol", 4'b0011, 1'b1, 1'b0, 1'b0);
    mode = LOAD; din = 4'b1001;
    step();
    mode = ROR;
    step(); chk_all("ror", 4'b1100, 1'b1, 1'b0, 1'b0);

    // Serial out of 1011 with LOAD applied during busy (ignored).
    mode = SEROUT; din = 4'b1011; sin = 1'b0;
    step(); chk_all("so1_start", 4'b1011, 1'b1, 1'b1, 1'b0);
    mode = LOAD; din = 4'b1111;
    step(); chk_all("so1_j1", 4'b0110, 1'b1, 1'b1, 1'b0);
    step(); chk_all("so1_j2", 4'b1100, 1'b0, 1'b1, 1'b0);
    step(); chk_all("so1_j3", 4'b1000, 1'b1, 1'b1, 1'b0);
    step(); chk_all("so1_j4", 4'b0000, 1'b1, 1'b0, 1'b1);
    mode = HOLD;
    step(); chk_all("so1_after", 4'b0000, 1'b1, 1'b0, 1'b0);

    // Serial out of 1100 with a two-cycle stall after the first shift.
    mode = SEROUT; din = 4'b1100;
    step(); chk_all("so2_start", 4'b1100, 1'b1, 1'b1, 1'b0);
    mode = HOLD;
    step(); chk_all("so2_j1", 4'b1000, 1'b1, 1'b1, 1'b0);
    en = 1'b0;
    step(); chk_all("so2_stall1", 4'b1000, 1'b1, 1'b1, 1'b0);
    step(); chk_all("so2_stall2", 4'b1000, 1'b1, 1'b1, 1'b0);
    en = 1'b1;
    step(); chk_all("so2_j2", 4'b0000, 1'b1, 1'b1, 1'b0);
    step(); chk_all("so2_j3", 4'b0000, 1'b0, 1'b1, 1'b0);
    step(); chk_all("so2_j4", 4'b0000, 1'b0, 1'b0, 1'b1);
    step(); chk_all("so2_after", 4'b0000, 1'b0, 1'b0, 1'b0);

    // Reset aborts a sequence of 1111 after two shifts.
    mode = SEROUT; din = 4'b1111;
    step(); chk_all("so3_start", 4'b1111, 1'b0, 1'b1, 1'b0);
    mode = HOLD;
    step(); step(); chk_all("so3_j2", 4'b1100, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0; mode = LOAD; din = 4'b0110;
    step(); chk_all("so3_reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(); chk_all("so3_load", 4'b0110, 1'b0, 1'b0, 1'b0);
    mode = HOLD;
    step(); chk_all("so3_nodone1", 4'b0110, 1'b0, 1'b0, 1'b0);
    step(); chk_all("so3_nodone2", 4'b0110, 1'b0, 1'b0, 1'b0);

    // Fresh sequence after the abort still takes the full four shifts.
    mode = SEROUT; din = 4'b1010;
    step(); chk_all("so4_start", 4'b1010, 1'b0, 1'b1, 1'b0);
    mode = HOLD;
    step(); chk_all("so4_j1", 4'b0100, 1'b1, 1'b1, 1'b0);
    step(); chk_all("so4_j2", 4'b1000, 1'b0, 1'b1, 1'b0);
    step(); chk_all("so4_j3", 4'b0000, 1'b1, 1'b1, 1'b0);
    step(); chk_all("so4_j4", 4'b0000, 1'b0, 1'b0, 1'b1);
    step(); chk_all("so4_after", 4'b0000, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
